// File: rtl/alu_select_pipe.sv
// alu_select_pipe
//   Two-stage valid/ready ALU pipeline. Stage 1 captures the request
//   (op, a, b). Stage 2 evaluates the selected operation and holds the result
//   and its flags until the consumer takes them.
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid_i   request valid
//   in_ready_o   stage 1 can accept a request (combinational)
//   op_i         4-bit operation select
//   a_i, b_i     operands, WIDTH bits
//   out_valid_o  result valid
//   out_ready_i  consumer accepts the result
//   x_o          result, WIDTH bits
//   flags_o      {N, Z, C, V} describing x_o
//   err_o        sticky: a reserved op reached stage 2
//   op_count_o   number of results consumed, wraps at 2^CNT_W
module alu_select_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] x_o,
  output logic [3:0]       flags_o,
  output logic             err_o,
  output logic [CNT_W-1:0] op_count_o
);

  localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

  logic             s1_valid_q, s1_valid_d;
  logic [3:0]       s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic             s2_load;
  logic             req_xfer;
  logic             res_xfer;
  logic [WIDTH-1:0] alu_x;
  logic             alu_c;
  logic             alu_v;
  logic [WIDTH:0]   sum_ext;

  // Stage 2 refills whenever it is empty or its result leaves this cycle,
  // which lets stage 1 accept a new request in that same cycle.
  assign s2_load    = s1_valid_q && (!s2_valid_q || out_ready_i);
  assign in_ready_o = !s1_valid_q || s2_load;
  assign req_xfer   = in_valid_i && in_ready_o;
  assign res_xfer   = s2_valid_q && out_ready_i;

  // Operation evaluation on the stage 1 registers. Subtraction and negation
  // are done as a + ~b + 1 in WIDTH+1 bits so the top bit is the carry-out.
  always_comb begin
    alu_x   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    sum_ext = '0;
    case (s1_op_q)
      4'h0: alu_x = s1_a_q;
      4'h1: alu_x = s1_b_q;
      4'h2: begin
        sum_ext = {1'b0, ~s1_a_q} + ONE_EXT;
        alu_x   = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        // 0 - a overflows only when a is the most negative value
        alu_v   = s1_a_q[WIDTH-1] & alu_x[WIDTH-1];
      end
      4'h3: begin
        sum_ext = {1'b0, ~s1_b_q} + ONE_EXT;
        alu_x   = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = s1_b_q[WIDTH-1] & alu_x[WIDTH-1];
      end
      4'h4: begin
        alu_x = {s1_a_q[0], s1_a_q[WIDTH-1:1]};
        alu_c = s1_a_q[0];
      end
      4'h5: begin
        alu_x = {s1_b_q[0], s1_b_q[WIDTH-1:1]};
        alu_c = s1_b_q[0];
      end
      4'h6: alu_x = {{(WIDTH-1){1'b0}}, ($signed(s1_a_q) < $signed(s1_b_q))};
      4'h7: alu_x = s1_a_q & s1_b_q;
      4'h8: alu_x = ~s1_a_q;
      4'h9: alu_x = ~s1_b_q;
      4'hA: begin
        sum_ext = {1'b0, s1_a_q} + {1'b0, ~s1_b_q} + ONE_EXT;
        alu_x   = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (s1_a_q[WIDTH-1] ^ s1_b_q[WIDTH-1]) & (alu_x[WIDTH-1] ^ s1_a_q[WIDTH-1]);
      end
      4'hB: begin
        sum_ext = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        alu_x   = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = ~(s1_a_q[WIDTH-1] ^ s1_b_q[WIDTH-1]) & (alu_x[WIDTH-1] ^ s1_a_q[WIDTH-1]);
      end
      // Reserved ops fall through to x=0 with no carry/overflow, so the
      // common flag logic below yields Z=1 and nothing else.
      default: begin
        alu_x = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
      end
    endcase
  end

  // Next-state for both pipeline stages, the sticky error and the counter.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s2_valid_d = s2_valid_q;
    x_d        = x_q;
    flags_d    = flags_q;
    err_d      = err_q;
    op_count_d = op_count_q;

    if (req_xfer) begin
      s1_valid_d = 1'b1;
      s1_op_d    = op_i;
      s1_a_d     = a_i;
      s1_b_d     = b_i;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      s2_valid_d = 1'b1;
      x_d        = alu_x;
      flags_d    = {alu_x[WIDTH-1], (alu_x == '0), alu_c, alu_v};
      if (s1_op_q[3:2] == 2'b11) begin
        err_d = 1'b1;
      end
    end else if (res_xfer) begin
      s2_valid_d = 1'b0;
    end

    if (res_xfer) begin
      op_count_d = op_count_q + CNT_W'(1);
    end
  end

  // State registers; reset clears everything in flight immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      x_q        <= '0;
      flags_q    <= '0;
      err_q      <= 1'b0;
      op_count_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      x_q        <= x_d;
      flags_q    <= flags_d;
      err_q      <= err_d;
      op_count_q <= op_count_d;
    end
  end

  assign out_valid_o = s2_valid_q;
  assign x_o         = x_q;
  assign flags_o     = flags_q;
  assign err_o       = err_q;
  assign op_count_o  = op_count_q;

endmodule

// File: tb/tb_alu_select_pipe.sv
// tb_alu_select_pipe
//   Bench for alu_select_pipe (WIDTH=8, CNT_W=4 so the counter wraps quickly).
//   Known-answer vectors, hand-built stall/reset/error sequences and a random
//   valid/ready run scored against an arithmetic reference model.
module tb_alu_select_pipe;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  typedef struct {
    logic [WIDTH-1:0] x;
    logic [3:0]       flags;
    bit               reserved;
  } res_t;

  typedef struct {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] expX;
    logic [3:0]       expFlags;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             inValid;
  logic             inReady;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] x;
  logic [3:0]       flags;
  logic             err;
  logic [CNT_W-1:0] opCount;

  int errors = 0;
  int checks = 0;

  res_t             expQ[$];
  int               expCount;
  int               delivered;
  bit               anyReserved;
  bit               heldPrev;
  logic [WIDTH-1:0] heldX;
  logic [3:0]       heldF;

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  alu_select_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (inValid),
    .in_ready_o (inReady),
    .op_i       (op),
    .a_i        (a),
    .b_i        (b),
    .out_valid_o(outValid),
    .out_ready_i(outReady),
    .x_o        (x),
    .flags_o    (flags),
    .err_o      (err),
    .op_count_o (opCount)
  );

  // Single comparison point: counts the check and reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // Reference ALU built from plain integer arithmetic on the operand values.
  function automatic res_t refModel(input logic [3:0] opIn, input logic [WIDTH-1:0] aIn, input logic [WIDTH-1:0] bIn);
    res_t   r;
    longint m    = longint'(1) << WIDTH;
    longint half = m / 2;
    longint ua   = longint'(aIn);
    longint ub   = longint'(bIn);
    longint sa   = (ua >= half) ? ua - m : ua;
    longint sb   = (ub >= half) ? ub - m : ub;
    longint full = 0;
    longint sres = 0;
    longint val  = 0;
    bit     c    = 1'b0;
    bit     v    = 1'b0;
    case (int'(opIn))
      0:  val = ua;
      1:  val = ub;
      2:  begin full = (m - 1 - ua) + 1; val = full % m; c = (full >= m); sres = -sa; v = (sres > half - 1) || (sres < -half); end
      3:  begin full = (m - 1 - ub) + 1; val = full % m; c = (full >= m); sres = -sb; v = (sres > half - 1) || (sres < -half); end
      4:  begin val = (ua / 2) + (ua % 2) * half; c = (ua % 2) == 1; end
      5:  begin val = (ub / 2) + (ub % 2) * half; c = (ub % 2) == 1; end
      6:  val = (sa < sb) ? 1 : 0;
      7:  val = ua & ub;
      8:  val = m - 1 - ua;
      9:  val = m - 1 - ub;
      10: begin full = ua + (m - 1 - ub) + 1; val = full % m; c = (full >= m); sres = sa - sb; v = (sres > half - 1) || (sres < -half); end
      11: begin full = ua + ub; val = full % m; c = (full >= m); sres = sa + sb; v = (sres > half - 1) || (sres < -half); end
      default: val = 0;
    endcase
    r.x        = val[WIDTH-1:0];
    r.flags    = {(val >= half), (val == 0), c, v};
    r.reserved = (opIn >= 4'd12);
    return r;
  endfunction

  // Offers one request and returns once it has been taken (bounded wait).
  task automatic applyStimulus(input logic [3:0] opIn, input logic [WIDTH-1:0] aIn, input logic [WIDTH-1:0] bIn, output int waits);
    bit acc = 1'b0;
    inValid = 1'b1;
    op      = opIn;
    a       = aIn;
    b       = bIn;
    waits   = 0;
    #1;
    repeat (20) begin
      acc = inReady;
      @(posedge clk);
      #1;
      if (acc) break;
      waits++;
    end
    inValid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0, required 1 within 20 cycles");
    end
  endtask

  // One clock of scoreboarded traffic: transfers are decided from the
  // signals seen at the falling edge, which are stable until the rising edge.
  task automatic runCycle(output bit accepted);
    bit   reqX;
    bit   resX;
    res_t e;
    @(negedge clk);
    if (heldPrev) begin
      checkOutput("hold_valid", 32'(outValid), 32'd1);
      checkOutput("hold_x", 32'(x), 32'(heldX));
      checkOutput("hold_flags", 32'(flags), 32'(heldF));
    end
    heldPrev = outValid && !outReady;
    heldX    = x;
    heldF    = flags;
    if (!anyReserved) checkOutput("err_clear", 32'(err), 32'd0);
    reqX = inValid && inReady;
    resX = outValid && outReady;
    if (resX) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result: got x=0x%0h, required no result", x);
      end else begin
        e = expQ.pop_front();
        checkOutput("stream_x", 32'(x), 32'(e.x));
        checkOutput("stream_flags", 32'(flags), 32'(e.flags));
        if (e.reserved) checkOutput("err_set", 32'(err), 32'd1);
      end
      delivered++;
    end
    if (reqX) begin
      e = refModel(op, a, b);
      expQ.push_back(e);
      if (e.reserved) anyReserved = 1'b1;
    end
    @(posedge clk);
    #1;
    if (resX) expCount = (expCount + 1) % (1 << CNT_W);
    checkOutput("op_count", 32'(opCount), 32'(expCount));
    accepted = reqX;
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t             vecs[12];
    logic [3:0]       stallOps[4];
    logic [WIDTH-1:0] stallA[4];
    logic [WIDTH-1:0] xSnap;
    int               waits;
    int               idx;
    bit               acc;

    //           op     a      b      x      NZCV
    vecs[0]  = '{4'hB, 8'hF0, 8'h20, 8'h10, 4'b0010};
    vecs[1]  = '{4'hB, 8'h7F, 8'h01, 8'h80, 4'b1001};
    vecs[2]  = '{4'hA, 8'h05, 8'h05, 8'h00, 4'b0110};
    vecs[3]  = '{4'h4, 8'h01, 8'h00, 8'h80, 4'b1010};
    vecs[4]  = '{4'h6, 8'h80, 8'h01, 8'h01, 4'b0000};
    vecs[5]  = '{4'h2, 8'h80, 8'h00, 8'h80, 4'b1001};
    vecs[6]  = '{4'h2, 8'h00, 8'h00, 8'h00, 4'b0110};
    vecs[7]  = '{4'h7, 8'hCC, 8'hAA, 8'h88, 4'b1000};
    vecs[8]  = '{4'h8, 8'h0F, 8'h00, 8'hF0, 4'b1000};
    vecs[9]  = '{4'hA, 8'h00, 8'h01, 8'hFF, 4'b1000};
    vecs[10] = '{4'h5, 8'h00, 8'h02, 8'h01, 4'b0000};
    vecs[11] = '{4'h3, 8'h00, 8'h01, 8'hFF, 4'b1000};

    stallOps = '{4'h0, 4'h8, 4'hB, 4'h1};
    stallA   = '{8'h11, 8'h22, 8'h33, 8'h44};

    rst_n    = 1'b0;
    inValid  = 1'b0;
    op       = '0;
    a        = '0;
    b        = '0;
    outReady = 1'b1;
    expCount = 0;
    delivered   = 0;
    anyReserved = 1'b0;
    heldPrev    = 1'b0;

    // Reset state, sampled with clock edges passing under reset.
    #2;
    checkOutput("rst_out_valid", 32'(outValid), 32'd0);
    checkOutput("rst_in_ready", 32'(inReady), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_x", 32'(x), 32'd0);
    checkOutput("rst_flags", 32'(flags), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_op_count", 32'(opCount), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Known-answer vectors, one at a time with the consumer always ready.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, waits);
      if (i == 0) checkOutput("first_edge_accept", 32'(waits), 32'd0);
      checkOutput($sformatf("vec%0d_latency_early", i), 32'(outValid), 32'd0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_valid", i), 32'(outValid), 32'd1);
      checkOutput($sformatf("vec%0d_x", i), 32'(x), 32'(vecs[i].expX));
      checkOutput($sformatf("vec%0d_flags", i), 32'(flags), 32'(vecs[i].expFlags));
    end
    checkOutput("err_after_legal", 32'(err), 32'd0);

    // Reserved op delivers zero with Z and sets the sticky error.
    applyStimulus(4'hC, 8'h5A, 8'hA5, waits);
    @(posedge clk);
    #1;
    checkOutput("rsv_valid", 32'(outValid), 32'd1);
    checkOutput("rsv_x", 32'(x), 32'd0);
    checkOutput("rsv_flags", 32'(flags), 32'b0100);
    checkOutput("rsv_err", 32'(err), 32'd1);
    applyStimulus(4'h0, 8'h33, 8'h00, waits);
    @(posedge clk);
    #1;
    checkOutput("after_rsv_x", 32'(x), 32'h33);
    checkOutput("after_rsv_err", 32'(err), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("drained", 32'(outValid), 32'd0);

    // Fill both stages with the consumer stalled, then reset mid-cycle.
    outReady = 1'b0;
    inValid  = 1'b1;
    op = 4'hB; a = 8'h01; b = 8'h02;
    @(posedge clk);
    #1;
    op = 4'h1; b = 8'h77;
    @(posedge clk);
    #1;
    op = 4'h0; a = 8'h99;
    checkOutput("full_in_ready", 32'(inReady), 32'd0);
    checkOutput("full_out_valid", 32'(outValid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_out_valid", 32'(outValid), 32'd0);
    checkOutput("async_rst_in_ready", 32'(inReady), 32'd1);
    checkOutput("async_rst_x", 32'(x), 32'd0);
    checkOutput("async_rst_flags", 32'(flags), 32'd0);
    checkOutput("async_rst_err", 32'(err), 32'd0);
    checkOutput("async_rst_op_count", 32'(opCount), 32'd0);
    inValid = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    outReady = 1'b1;
    expQ.delete();
    expCount    = 0;
    delivered   = 0;
    anyReserved = 1'b0;
    heldPrev    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      runCycle(acc);
      checkOutput("no_stale_result", 32'(outValid), 32'd0);
    end

    // Stream four ops into a stalled consumer, then release it.
    outReady = 1'b0;
    idx   = 0;
    xSnap = '0;
    for (int c = 0; c < 6; c++) begin
      inValid = 1'b1;
      op = stallOps[idx]; a = stallA[idx]; b = 8'h0F;
      runCycle(acc);
      if (acc) idx++;
      if (c == 2) xSnap = x;
    end
    checkOutput("stall_accepted", 32'(idx), 32'd2);
    checkOutput("stall_in_ready", 32'(inReady), 32'd0);
    checkOutput("stall_x_stable", 32'(x), 32'(xSnap));
    outReady = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (idx < 4) begin
        inValid = 1'b1;
        op = stallOps[idx]; a = stallA[idx]; b = 8'h0F;
      end else begin
        inValid = 1'b0;
      end
      runCycle(acc);
      if (acc) idx++;
      if (idx == 4 && expQ.size() == 0) break;
    end
    checkOutput("stall_delivered", 32'(delivered), 32'd4);
    checkOutput("stall_op_count", 32'(opCount), 32'd4);

    // Random traffic with random back-pressure; the counter wraps here.
    for (int c = 0; c < 600; c++) begin
      inValid  = ($urandom_range(0, 3) != 0);
      outReady = ($urandom_range(0, 3) != 0);
      op = 4'($urandom_range(0, 15));
      a  = WIDTH'($urandom);
      b  = WIDTH'($urandom);
      runCycle(acc);
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    for (int c = 0; c < 10; c++) begin
      runCycle(acc);
      if (expQ.size() == 0 && !outValid) break;
    end
    checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_select_pipe.md
ALU_SELECT_PIPE -- requirements
Module: alu_select_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal 4..32).
REQ-002 Parameter CNT_W, default 16, width of completed-operation counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  stage 1 can accept a request.
REQ-007 op  input  4  operation select.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 x  output  WIDTH  result.
REQ-013 flags  output  4  {N, Z, C, V} for the result on x.
REQ-014 err  output  1  sticky: a reserved op was accepted.
REQ-015 op_count  output  CNT_W  number of results consumed.

Function
REQ-016 Request transfer occurs when in_valid and in_ready are both 1 on a rising edge; result transfer occurs when out_valid and out_ready are both 1.
REQ-017 Two-stage pipeline: stage 1 registers op/a/b; stage 2 computes and registers x/flags; latency is 2 cycles from request transfer to out_valid with no stall.
REQ-018 Stage 2 loads when stage 1 is valid and (stage 2 empty or result transfer in same cycle).
REQ-019 in_ready = !s1_valid or stage 2 loads this cycle (combinational); full throughput of 1 op/cycle when out_ready=1.
REQ-020 When out_ready=0 and both stages are full: in_ready=0; x, flags, and out_valid hold stable.
REQ-021 Op map: 0000 a; 0001 b; 0010 -a; 0011 -b; 0100 ror1(a); 0101 ror1(b); 0110 signed(a<b) ? 1 : 0 (zero-extended); 0111 a&b; 1000 ~a; 1001 ~b; 1010 a-b; 1011 a+b.
REQ-022 Ops 1100-1111 are reserved: x=0, flags Z=1 and others 0, result still delivered; err is set on the cycle the op enters stage 2.
REQ-023 All arithmetic is modulo 2^WIDTH; negation is two's complement.
REQ-024 N = x[WIDTH-1]; Z = (x==0).
REQ-025 C: add = carry-out of a+b; sub = carry-out of a+~b+1 (1 means no borrow); neg = carry-out of ~op+1; ror = bit rotated out (old bit 0); otherwise 0.
REQ-026 V: add = signed overflow of a+b; sub/neg = signed overflow of the subtraction (e.g. -0x80 gives V=1); otherwise 0.
REQ-027 op_count increments by 1 on each result transfer and wraps from 2^CNT_W-1 to 0.
REQ-028 Simultaneous request transfer and result transfer with both stages full: both occur; no data is lost or duplicated.
REQ-029 err remains 1 until reset; it is not cleared by later legal ops.

Reset
REQ-030 While rst_n=0: stage valids=0, out_valid=0, in_ready=1, x=0, flags=0, err=0, op_count=0.
REQ-031 Reset asserted mid-operation discards all in-flight requests immediately, without waiting for a clock edge.
REQ-032 First request transfer is possible on the first rising edge after rst_n deasserts.

Verification
REQ-033 WIDTH=8, out_ready=1, op=1011, a=0xF0, b=0x20 -> 2 cycles later out_valid=1, x=0x10, flags N0 Z0 C1 V0.
REQ-034 op=1011, a=0x7F, b=0x01 -> x=0x80, N1 Z0 C0 V1; op=1010, a=0x05, b=0x05 -> x=0x00, N0 Z1 C1 V0.
REQ-035 op=0100, a=0x01 -> x=0x80, N1 C1; op=0110, a=0x80, b=0x01 -> x=0x01.
REQ-036 Stream 4 ops with out_ready=0 -> in_ready drops after 2 accepted, x stable; then out_ready=1 -> all 4 results delivered in order, op_count=4.
REQ-037 op=1100 -> x=0x00, Z=1, err=1 and err stays 1 after subsequent op=0000.
REQ-038 Pulse rst_n low with both stages full -> out_valid=0, op_count=0, err=0 immediately; no stale result appears after reset deasserts.
